// File: rtl/stage_chain_pkg.sv
// Shared defaults and sizing helpers for the stage_chain pipeline.
package stage_chain_pkg;

  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_DEPTH  = 2;
  localparam int unsigned DEF_OFFSET = 1;

  // Bits needed to count 0..depth words inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stage_chain_pipe_stage.sv
// One valid/data register of the chain; the last stage adds the constant offset.
module pipe_stage
  import stage_chain_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter bit          ADD_OFFSET = 1'b0,
  parameter int unsigned OFFSET     = DEF_OFFSET
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam logic [WIDTH-1:0] INC = ADD_OFFSET ? WIDTH'(OFFSET) : '0;

  // Data only moves with a valid word so an empty load leaves the register quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= prev_valid;
      if (prev_valid) begin
        data <= prev_data + INC;
      end
    end
  end

endmodule

// File: rtl/stage_chain.sv
// Elastic valid/ready register chain of DEPTH stages with an offset added at the output stage.
module stage_chain
  import stage_chain_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned OFFSET = DEF_OFFSET
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
  input  logic                          out_ready,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH:0]   ready_chain;
  logic [DEPTH-1:0] load;
  logic             accept;
  logic             emit;

  // A stage may load when it is empty or its successor takes its word this cycle.
  always_comb begin
    ready_chain        = '0;
    ready_chain[DEPTH] = out_ready;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      ready_chain[k] = !valid_q[k] || ready_chain[k+1];
    end
  end

  assign load     = ready_chain[DEPTH-1:0];
  assign in_ready = ready_chain[0];
  assign accept   = in_valid && ready_chain[0];
  assign emit     = valid_q[DEPTH-1] && out_ready;

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    logic             prev_valid;
    logic [WIDTH-1:0] prev_data;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_data  = in_data;
    end else begin : g_body
      assign prev_valid = valid_q[k-1];
      assign prev_data  = data_q[k-1];
    end

    pipe_stage #(
      .WIDTH      (WIDTH),
      .ADD_OFFSET (k == int'(DEPTH) - 1),
      .OFFSET     (OFFSET)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load[k]),
      .prev_valid (prev_valid),
      .prev_data  (prev_data),
      .valid      (valid_q[k]),
      .data       (data_q[k])
    );
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Word count tracks handshakes; simultaneous accept and emit cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (accept && !emit) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (emit && !accept) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

endmodule

// File: tb/tb_stage_chain.sv
// Directed and randomised checks of stage_chain at several depths and offsets.
module tb_stage_chain;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;

  logic       r_in_valid  [3];
  logic [7:0] r_in_data   [3];
  logic       r_in_ready  [3];
  logic       r_out_valid [3];
  logic [7:0] r_out_data  [3];
  logic       r_out_ready [3];
  logic [0:0] r_occ0;
  logic [2:0] r_occ1;
  logic [4:0] r_occ2;

  logic [7:0] sb [3][64];
  int head [3];
  int tail [3];

  int checks;
  int failures;

  stage_chain u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready), .occupancy(a_occ));

  stage_chain #(.OFFSET(32'h80)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready), .occupancy(b_occ));

  stage_chain #(.DEPTH(1)) u_r0 (
    .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[0]), .in_data(r_in_data[0]), .in_ready(r_in_ready[0]),
    .out_valid(r_out_valid[0]), .out_data(r_out_data[0]), .out_ready(r_out_ready[0]), .occupancy(r_occ0));

  stage_chain #(.DEPTH(4)) u_r1 (
    .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[1]), .in_data(r_in_data[1]), .in_ready(r_in_ready[1]),
    .out_valid(r_out_valid[1]), .out_data(r_out_data[1]), .out_ready(r_out_ready[1]), .occupancy(r_occ1));

  stage_chain #(.DEPTH(16)) u_r2 (
    .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid[2]), .in_data(r_in_data[2]), .in_ready(r_in_ready[2]),
    .out_valid(r_out_valid[2]), .out_data(r_out_data[2]), .out_ready(r_out_ready[2]), .occupancy(r_occ2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int rdepth(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 16;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", a_out_data); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    @(negedge clk);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h10;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL lat_in_ready got=%0b exp=1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL lat_occ1 got=%0d exp=1", a_occ); end
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL lat_early_valid got=%0b exp=0", a_out_valid); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL lat_out_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_data !== 8'h11) begin failures++; $display("FAIL lat_out_data got=%0h exp=11", a_out_data); end
    checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL lat_occ2 got=%0d exp=1", a_occ); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL lat_drained got=%0b exp=0", a_out_valid); end
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL lat_occ_end got=%0d exp=0", a_occ); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'hFF;
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 8'h90;
    @(negedge clk);
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL wrap_a_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin failures++; $display("FAIL wrap_a_data got=%0h exp=00", a_out_data); end
    checks++; if (b_out_valid !== 1'b1) begin failures++; $display("FAIL wrap_b_valid got=%0b exp=1", b_out_valid); end
    checks++; if (b_out_data !== 8'h10) begin failures++; $display("FAIL wrap_b_data got=%0h exp=10", b_out_data); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h01;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%0b exp=1", a_in_ready); end
    @(negedge clk);
    a_in_data = 8'h02;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready2 got=%0b exp=1", a_in_ready); end
    @(negedge clk);
    a_in_data = 8'h03;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%0b exp=0", a_in_ready); end
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_occ_full got=%0d exp=2", a_occ); end
    checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", a_out_valid); end
    checks++; if (a_out_data !== 8'h02) begin failures++; $display("FAIL bp_head got=%0h exp=02", a_out_data); end
    @(negedge clk);
    checks++; if (a_out_data !== 8'h02) begin failures++; $display("FAIL bp_stable got=%0h exp=02", a_out_data); end
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_occ_hold got=%0d exp=2", a_occ); end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", a_in_ready); end
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== 8'h03) begin failures++; $display("FAIL bp_out2 got=%0h exp=03", a_out_data); end
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL bp_occ_swap got=%0d exp=2", a_occ); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h04) begin failures++; $display("FAIL bp_out3 got=%0b/%0h exp=1/04", a_out_valid, a_out_data); end
    checks++; if (a_occ !== 2'd1) begin failures++; $display("FAIL bp_occ_one got=%0d exp=1", a_occ); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin failures++; $display("FAIL bp_empty got=%0b/%0d exp=0/0", a_out_valid, a_occ); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h30;
    @(negedge clk);
    a_in_data = 8'h31;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL b2b_occ[%0d] got=%0d exp=2", i, a_occ); end
      a_in_data = 8'(8'h32 + i); a_out_ready = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h31 + i)) begin
        failures++; $display("FAIL b2b_out[%0d] got=%0b/%0h exp=1/%0h", i, a_out_valid, a_out_data, 8'(8'h31 + i));
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_data !== 8'h3B) begin failures++; $display("FAIL b2b_tail1 got=%0h exp=3b", a_out_data); end
    @(negedge clk);
    checks++; if (a_out_data !== 8'h3C) begin failures++; $display("FAIL b2b_tail2 got=%0h exp=3c", a_out_data); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin failures++; $display("FAIL b2b_empty got=%0b/%0d exp=0/0", a_out_valid, a_occ); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 8'h40;
    @(negedge clk);
    a_in_data = 8'h41;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_occ !== 2'd2) begin failures++; $display("FAIL mid_fill got=%0d exp=2", a_occ); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", a_out_valid); end
    checks++; if (a_occ !== 2'd0) begin failures++; $display("FAIL mid_occ got=%0d exp=0", a_occ); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", a_in_ready); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_data = 8'h20;
    @(negedge clk);
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale got=%0b exp=0", a_out_valid); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h21) begin failures++; $display("FAIL mid_out got=%0b/%0h exp=1/21", a_out_valid, a_out_data); end
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin failures++; $display("FAIL mid_empty got=%0b/%0d exp=0/0", a_out_valid, a_occ); end
  endtask

  task automatic test_random();
    int occ;
    int size;
    logic exp_ready;
    for (int i = 0; i < 3; i++) begin head[i] = 0; tail[i] = 0; end
    for (int c = 0; c < 750; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        occ = (i == 0) ? int'(r_occ0) : (i == 1) ? int'(r_occ1) : int'(r_occ2);
        checks++; if (occ != tail[i] - head[i]) begin failures++; $display("FAIL rnd_occ d%0d c%0d got=%0d exp=%0d", rdepth(i), c, occ, tail[i] - head[i]); end
        if (c < 600) begin
          r_in_valid[i]  = 1'($urandom_range(0, 1));
          r_in_data[i]   = 8'($urandom);
          r_out_ready[i] = ($urandom_range(0, 3) < ((c < 300) ? 1 : 3));
        end else begin
          r_in_valid[i]  = 1'b0;
          r_out_ready[i] = 1'b1;
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        size = tail[i] - head[i];
        exp_ready = r_out_ready[i] || (size < rdepth(i));
        checks++; if (r_in_ready[i] !== exp_ready) begin failures++; $display("FAIL rnd_ready d%0d c%0d got=%0b exp=%0b", rdepth(i), c, r_in_ready[i], exp_ready); end
        if (r_out_valid[i] === 1'b1 && r_out_ready[i]) begin
          checks++;
          if (size == 0) begin
            failures++; $display("FAIL rnd_extra d%0d c%0d got=%0h exp=none", rdepth(i), c, r_out_data[i]);
          end else begin
            if (r_out_data[i] !== sb[i][head[i] % 64]) begin
              failures++; $display("FAIL rnd_data d%0d c%0d got=%0h exp=%0h", rdepth(i), c, r_out_data[i], sb[i][head[i] % 64]);
            end
            head[i]++;
          end
        end
        if (r_in_valid[i] && exp_ready) begin
          sb[i][tail[i] % 64] = 8'(r_in_data[i] + 8'd1);
          tail[i]++;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (tail[i] != head[i]) begin failures++; $display("FAIL rnd_drain d%0d got=%0d exp=0", rdepth(i), tail[i] - head[i]); end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r_in_valid[i] = 1'b0; r_in_data[i] = '0; r_out_ready[i] = 1'b0;
    end
    test_reset();
    test_latency();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
